// File: rtl/sync_ram_init.sv
// Single-clock RAM with a registered, write-first read port and a hardware
// initialisation sweep that loads INIT_VALUE into every word after reset or clr.
module sync_ram_init #(
  parameter int unsigned            ADDR_WIDTH = 4,
  parameter int unsigned            DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0]  INIT_VALUE = '0
) (
  input  logic                  clk_2,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  req_drop
);

  localparam int unsigned           DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic {INIT, READY} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   sweep_q, sweep_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic                    rd_valid_q, rd_valid_d;
  logic                    req_drop_q, req_drop_d;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;

  always_comb begin
    state_d    = state_q;
    sweep_d    = sweep_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    req_drop_d = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = wr_addr;
    mem_wdata  = wr_data;

    unique case (state_q)
      INIT: begin
        req_drop_d = wr_en | rd_en;
        if (clr) begin
          sweep_d = '0;
        end else begin
          // The sweep owns the single write port while initialising.
          mem_we    = 1'b1;
          mem_waddr = sweep_q;
          mem_wdata = INIT_VALUE;
          if (sweep_q == LAST_ADDR) begin
            state_d = READY;
          end else begin
            sweep_d = sweep_q + 1'b1;
          end
        end
      end

      READY: begin
        if (clr) begin
          state_d    = INIT;
          sweep_d    = '0;
          req_drop_d = wr_en | rd_en;
        end else begin
          mem_we = wr_en;
          if (rd_en) begin
            rd_valid_d = 1'b1;
            rd_data_d  = (wr_en && (rd_addr == wr_addr)) ? wr_data : mem[rd_addr];
          end
        end
      end

      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_q    <= INIT;
      sweep_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      req_drop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sweep_q    <= sweep_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      req_drop_q <= req_drop_d;
    end
  end

  always_ff @(posedge clk_2) begin
    if (!reset && mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign req_drop = req_drop_q;
  assign busy     = (state_q == INIT);

endmodule

// File: tb/tb_sync_ram_init.sv
// Scoreboard bench for sync_ram_init: read expectations are queued at issue and
// popped when the registered response appears one edge later.
module tb_sync_ram_init;

  logic       clk_2 = 1'b0;
  logic       reset, clr, wr_en, rd_en;
  logic [3:0] wr_addr, rd_addr;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       rd_valid, busy, req_drop;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [7:0]  sb [$];

  sync_ram_init #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .INIT_VALUE(8'h00)) dut (
    .clk_2   (clk_2),
    .reset   (reset),
    .clr     (clr),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .busy    (busy),
    .req_drop(req_drop)
  );

  always #5 clk_2 = ~clk_2;

  task automatic step();
    @(posedge clk_2);
    #1;
  endtask

  task automatic idle();
    clr = 0; wr_en = 0; rd_en = 0;
  endtask

  task automatic test_reset();
    int n;
    logic [7:0] exp;
    idle(); reset = 1; wr_addr = 0; wr_data = 0; rd_addr = 0;
    step();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b exp=1", busy); end
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
    checks++; if (req_drop !== 1'b0) begin failures++; $display("FAIL reset_req_drop got=%b exp=0", req_drop); end
    reset = 0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin step(); n++; end
    checks++; if (n != 16) begin failures++; $display("FAIL reset_sweep_len got=%0d exp=16", n); end
    for (int i = 0; i < 16; i++) begin
      rd_en = 1; rd_addr = 4'(i); sb.push_back(8'h00);
      step();
      exp = sb.pop_front();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp) begin
        failures++; $display("FAIL init_read[%0d] got=%b/%h exp=1/%h", i, rd_valid, rd_data, exp);
      end
    end
    idle(); step();
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL init_idle_valid got=%b exp=0", rd_valid); end
  endtask

  task automatic test_write_read();
    logic [7:0] exp;
    wr_en = 1; wr_addr = 3; wr_data = 8'hA5;
    step();
    wr_en = 0; rd_en = 1; rd_addr = 3; sb.push_back(8'hA5);
    step();
    exp = sb.pop_front();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== exp) begin
      failures++; $display("FAIL wr_rd got=%b/%h exp=1/%h", rd_valid, rd_data, exp);
    end
    idle(); step();
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 8'hA5) begin
      failures++; $display("FAIL rd_hold got=%b/%h exp=0/a5", rd_valid, rd_data);
    end
  endtask

  task automatic test_bypass();
    logic [7:0] exp;
    wr_en = 1; wr_addr = 7; wr_data = 8'h3C; rd_en = 1; rd_addr = 7; sb.push_back(8'h3C);
    step();
    exp = sb.pop_front();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== exp) begin
      failures++; $display("FAIL bypass got=%b/%h exp=1/%h", rd_valid, rd_data, exp);
    end
    idle(); wr_en = 1; wr_addr = 2; wr_data = 8'h22;
    step();
    wr_en = 1; wr_addr = 1; wr_data = 8'h11; rd_en = 1; rd_addr = 2; sb.push_back(8'h22);
    step();
    exp = sb.pop_front();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== exp) begin
      failures++; $display("FAIL diff_addr_rd got=%b/%h exp=1/%h", rd_valid, rd_data, exp);
    end
    wr_en = 0; rd_en = 1; rd_addr = 1; sb.push_back(8'h11);
    step();
    exp = sb.pop_front();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== exp) begin
      failures++; $display("FAIL diff_addr_wr got=%b/%h exp=1/%h", rd_valid, rd_data, exp);
    end
    rd_addr = 7; sb.push_back(8'h3C);
    step();
    exp = sb.pop_front();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== exp) begin
      failures++; $display("FAIL bypass_stored got=%b/%h exp=1/%h", rd_valid, rd_data, exp);
    end
    idle();
  endtask

  task automatic test_busy_drop();
    int n;
    logic [7:0] exp;
    idle(); clr = 1;
    step();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL clr_busy got=%b exp=1", busy); end
    clr = 0;
    repeat (3) step();
    wr_en = 1; wr_addr = 5; wr_data = 8'hFF;
    step();
    checks++;
    if (req_drop !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL drop_pulse got=%b/%b exp=1/1", req_drop, busy);
    end
    wr_en = 0;
    step();
    checks++; if (req_drop !== 1'b0) begin failures++; $display("FAIL drop_once got=%b exp=0", req_drop); end
    n = 0;
    while (busy === 1'b1 && n < 40) begin step(); n++; end
    checks++; if (n != 11) begin failures++; $display("FAIL drop_sweep_rest got=%0d exp=11", n); end
    rd_en = 1; rd_addr = 5; sb.push_back(8'h00);
    step();
    exp = sb.pop_front();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== exp) begin
      failures++; $display("FAIL dropped_wr got=%b/%h exp=1/%h", rd_valid, rd_data, exp);
    end
    idle();
  endtask

  task automatic test_fill_clr();
    int n;
    logic [7:0] exp;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1; wr_addr = 4'(i); wr_data = 8'(i);
      step();
    end
    wr_en = 0;
    for (int i = 0; i < 16; i++) begin
      rd_en = 1; rd_addr = 4'(i); sb.push_back(8'(i));
      step();
      exp = sb.pop_front();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp) begin
        failures++; $display("FAIL fill[%0d] got=%b/%h exp=1/%h", i, rd_valid, rd_data, exp);
      end
    end
    idle(); clr = 1; wr_en = 1; wr_addr = 0; wr_data = 8'h99;
    step();
    checks++;
    if (req_drop !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL clr_drop got=%b/%b exp=1/1", req_drop, busy);
    end
    idle();
    n = 0;
    while (busy === 1'b1 && n < 40) begin step(); n++; end
    checks++; if (n != 16) begin failures++; $display("FAIL clr_sweep_len got=%0d exp=16", n); end
    for (int i = 0; i < 16; i++) begin
      rd_en = 1; rd_addr = 4'(i); sb.push_back(8'h00);
      step();
      exp = sb.pop_front();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp) begin
        failures++; $display("FAIL cleared[%0d] got=%b/%h exp=1/%h", i, rd_valid, rd_data, exp);
      end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    int n;
    logic bad_valid;
    idle(); clr = 1;
    step();
    clr = 0; rd_en = 1; rd_addr = 4;
    repeat (9) step();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy got=%b exp=1", busy); end
    reset = 1;
    repeat (2) step();
    checks++;
    if (busy !== 1'b1 || rd_valid !== 1'b0 || rd_data !== 8'h00) begin
      failures++; $display("FAIL mid_reset got=%b/%b/%h exp=1/0/00", busy, rd_valid, rd_data);
    end
    reset = 0;
    n = 0; bad_valid = 0;
    while (busy === 1'b1 && n < 40) begin
      step(); n++;
      if (rd_valid !== 1'b0) bad_valid = 1;
    end
    checks++; if (n != 16) begin failures++; $display("FAIL mid_sweep_len got=%0d exp=16", n); end
    checks++; if (bad_valid !== 1'b0) begin failures++; $display("FAIL mid_rd_valid got=%b exp=0", bad_valid); end
    idle(); step();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_busy_drop();
    test_fill_clr();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
